// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite motion controller: edge-mode encodings,
// 12-bit RGB colours and default visible-area bounds.
package sprite_pkg;

  typedef enum logic [1:0] {
    ModeWrap   = 2'd0,
    ModeClamp  = 2'd1,
    ModeBounce = 2'd2,
    ModeRsvd   = 2'd3
  } mode_e;

  localparam logic [11:0] White  = 12'hFFF;
  localparam logic [11:0] Red    = 12'hF00;
  localparam logic [11:0] Yellow = 12'hFF0;
  localparam logic [11:0] Cyan   = 12'h0FF;
  localparam logic [11:0] Green  = 12'h0F0;
  localparam logic [11:0] Blue   = 12'h00F;

  localparam int unsigned DefHMin = 144;
  localparam int unsigned DefHMax = 783;
  localparam int unsigned DefVMin = 35;
  localparam int unsigned DefVMax = 515;

endpackage

// File: rtl/sprite_axis.sv
// One axis of sprite motion: position and velocity-sign registers, updated only on tick_i,
// with wrap / clamp / bounce handling at the legal centre limits Lo..Hi.
module sprite_axis
  import sprite_pkg::*;
#(
  parameter int unsigned Lo    = 149,
  parameter int unsigned Hi    = 778,
  parameter int unsigned Step  = 2,
  parameter int unsigned Reset = 450
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_i,
  input  logic       inc_i,
  input  logic       dec_i,
  input  mode_e      mode_i,
  output logic [9:0] pos_o
);

  localparam logic signed [10:0] LoS   = 11'(Lo);
  localparam logic signed [10:0] HiS   = 11'(Hi);
  localparam logic signed [10:0] StepS = 11'(Step);

  logic [9:0]         pos_q, pos_d;
  logic               vel_neg_q, vel_neg_d;
  logic               vel_neg_b;
  logic signed [10:0] cur, fwd, bwd, nxt;

  always_comb begin
    cur       = $signed({1'b0, pos_q});
    fwd       = cur + StepS;
    bwd       = cur - StepS;
    nxt       = cur;
    vel_neg_b = vel_neg_q;
    pos_d     = pos_q;
    vel_neg_d = vel_neg_q;
    if (mode_i == ModeBounce) begin
      // Buttons only steer the velocity; reaching a limit overrides them.
      if (inc_i && !dec_i) begin
        vel_neg_b = 1'b0;
      end else if (dec_i && !inc_i) begin
        vel_neg_b = 1'b1;
      end
      nxt = vel_neg_b ? bwd : fwd;
      if (nxt >= HiS) begin
        pos_d     = HiS[9:0];
        vel_neg_d = 1'b1;
      end else if (nxt <= LoS) begin
        pos_d     = LoS[9:0];
        vel_neg_d = 1'b0;
      end else begin
        pos_d     = nxt[9:0];
        vel_neg_d = vel_neg_b;
      end
    end else begin
      if (inc_i && !dec_i) begin
        nxt = fwd;
      end else if (dec_i && !inc_i) begin
        nxt = bwd;
      end
      if (nxt > HiS) begin
        pos_d = (mode_i == ModeWrap) ? LoS[9:0] : HiS[9:0];
      end else if (nxt < LoS) begin
        pos_d = (mode_i == ModeWrap) ? HiS[9:0] : LoS[9:0];
      end else begin
        pos_d = nxt[9:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q     <= 10'(Reset);
      vel_neg_q <= 1'b0;
    end else if (tick_i) begin
      pos_q     <= pos_d;
      vel_neg_q <= vel_neg_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/sprite_motion_ctrl.sv
// VGA sprite controller: per-frame sprite motion from buttons or autonomous bounce, plus a
// registered pixel path. Define SPRITE_BORDER_EN to draw a 1-pixel BrdCol outline.
module sprite_motion_ctrl
  import sprite_pkg::*;
#(
  parameter int unsigned HalfW  = 5,
  parameter int unsigned HalfH  = 5,
  parameter int unsigned Step   = 2,
  parameter int unsigned HMin   = DefHMin,
  parameter int unsigned HMax   = DefHMax,
  parameter int unsigned VMin   = DefVMin,
  parameter int unsigned VMax   = DefVMax,
  parameter int unsigned ResetX = 450,
  parameter int unsigned ResetY = 250,
  parameter logic [11:0] SprCol = Red,
  parameter logic [11:0] BrdCol = 12'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_tick_i,
  input  logic        up_i,
  input  logic        down_i,
  input  logic        left_i,
  input  logic        right_i,
  input  logic [1:0]  mode_i,
  input  logic [9:0]  h_count_i,
  input  logic [9:0]  v_count_i,
  output logic [11:0] rgb_o,
  output logic [11:0] background_o,
  output logic        in_sprite_o,
  output logic [9:0]  xpos_o,
  output logic [9:0]  ypos_o
);

`ifdef SPRITE_BORDER_EN
  localparam bit BorderEn = 1'b1;
`else
  localparam bit BorderEn = 1'b0;
`endif

  localparam logic signed [10:0] HalfWS = 11'(HalfW);
  localparam logic signed [10:0] HalfHS = 11'(HalfH);

  mode_e mode;
  assign mode = mode_e'(mode_i);

  sprite_axis #(
    .Lo    (HMin + HalfW),
    .Hi    (HMax - HalfW),
    .Step  (Step),
    .Reset (ResetX)
  ) u_axis_x (
    .clk    (clk),
    .rst    (rst),
    .tick_i (frame_tick_i),
    .inc_i  (right_i),
    .dec_i  (left_i),
    .mode_i (mode),
    .pos_o  (xpos_o)
  );

  // Screen y grows downward, so "down" increments.
  sprite_axis #(
    .Lo    (VMin + HalfH),
    .Hi    (VMax - HalfH),
    .Step  (Step),
    .Reset (ResetY)
  ) u_axis_y (
    .clk    (clk),
    .rst    (rst),
    .tick_i (frame_tick_i),
    .inc_i  (down_i),
    .dec_i  (up_i),
    .mode_i (mode),
    .pos_o  (ypos_o)
  );

  logic [11:0]        bg_q, bg_d;
  logic [11:0]        rgb_q, rgb_d;
  logic               in_sprite_q, in_sprite_d;
  logic signed [10:0] h_s, v_s, x_lo, x_hi, y_lo, y_hi;
  logic               on_ring;

  always_comb begin
    bg_d = bg_q;
    if (right_i) begin
      bg_d = Yellow;
    end else if (left_i) begin
      bg_d = Cyan;
    end else if (down_i) begin
      bg_d = Green;
    end else if (up_i) begin
      bg_d = Blue;
    end
  end

  // Box edges are widened to 11 bits so a centre near zero cannot underflow.
  always_comb begin
    h_s  = $signed({1'b0, h_count_i});
    v_s  = $signed({1'b0, v_count_i});
    x_lo = $signed({1'b0, xpos_o}) - HalfWS;
    x_hi = $signed({1'b0, xpos_o}) + HalfWS;
    y_lo = $signed({1'b0, ypos_o}) - HalfHS;
    y_hi = $signed({1'b0, ypos_o}) + HalfHS;
    in_sprite_d = (h_s >= x_lo) && (h_s <= x_hi) && (v_s >= y_lo) && (v_s <= y_hi);
    on_ring     = (h_s == x_lo) || (h_s == x_hi) || (v_s == y_lo) || (v_s == y_hi);
    if (in_sprite_d) begin
      rgb_d = (BorderEn && on_ring) ? BrdCol : SprCol;
    end else begin
      rgb_d = bg_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bg_q        <= White;
      rgb_q       <= White;
      in_sprite_q <= 1'b0;
    end else begin
      bg_q        <= bg_d;
      rgb_q       <= rgb_d;
      in_sprite_q <= in_sprite_d;
    end
  end

  assign rgb_o        = rgb_q;
  assign background_o = bg_q;
  assign in_sprite_o  = in_sprite_q;

endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Directed bench for sprite_motion_ctrl: motion in each edge mode, button priority,
// pixel path and asynchronous reset. Honours SPRITE_BORDER_EN for expected pixel colours.
module tb_sprite_motion_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        frame_tick, up, down, left, right;
  logic [1:0]  mode;
  logic [9:0]  h_count, v_count;
  logic [11:0] rgb, background;
  logic        in_sprite;
  logic [9:0]  xpos, ypos;

  int checks = 0;
  int errors = 0;

`ifdef SPRITE_BORDER_EN
  localparam logic [11:0] EdgeCol = 12'h000;
`else
  localparam logic [11:0] EdgeCol = 12'hF00;
`endif

  sprite_motion_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_tick_i (frame_tick),
    .up_i         (up),
    .down_i       (down),
    .left_i       (left),
    .right_i      (right),
    .mode_i       (mode),
    .h_count_i    (h_count),
    .v_count_i    (v_count),
    .rgb_o        (rgb),
    .background_o (background),
    .in_sprite_o  (in_sprite),
    .xpos_o       (xpos),
    .ypos_o       (ypos)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk) frame_tick = 1'b1;
    @(negedge clk) frame_tick = 1'b0;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst = 1'b1; frame_tick = 1'b0;
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    mode = 2'd0; h_count = 10'd0; v_count = 10'd0;
    #12;
    check("reset_x", {2'b0, xpos}, 12'd450);
    check("reset_y", {2'b0, ypos}, 12'd250);
    check("reset_rgb", rgb, 12'hFFF);
    check("reset_bg", background, 12'hFFF);
    check("reset_in", {11'b0, in_sprite}, 12'd0);
    @(negedge clk) rst = 1'b0;

    // Wrap mode, moving right
    right = 1'b1;
    tick();
    check("wrap_x1", {2'b0, xpos}, 12'd452);
    check("bg_right", background, 12'hFF0);
    tick();
    check("wrap_x2", {2'b0, xpos}, 12'd454);
    tick();
    check("wrap_x3", {2'b0, xpos}, 12'd456);
    check("wrap_y", {2'b0, ypos}, 12'd250);
    ticks(161);
    check("wrap_at_hi", {2'b0, xpos}, 12'd778);
    tick();
    check("wrap_from_hi", {2'b0, xpos}, 12'd149);
    ticks(314);
    check("wrap_777", {2'b0, xpos}, 12'd777);
    tick();
    check("wrap_from_777", {2'b0, xpos}, 12'd149);
    ticks(314);
    check("pre_clamp", {2'b0, xpos}, 12'd777);

    // Clamp mode
    mode = 2'd1;
    tick();
    check("clamp_hi", {2'b0, xpos}, 12'd778);
    tick();
    check("clamp_hold", {2'b0, xpos}, 12'd778);

    right = 1'b0; down = 1'b1;
    ticks(129);
    check("clamp_down_y", {2'b0, ypos}, 12'd508);
    check("clamp_down_x", {2'b0, xpos}, 12'd778);
    check("bg_down", background, 12'h0F0);

    // Bounce mode: x already at its limit, y two short of it
    down = 1'b0; mode = 2'd2;
    tick();
    check("bounce_y_lim", {2'b0, ypos}, 12'd510);
    check("bounce_x_lim", {2'b0, xpos}, 12'd778);
    tick();
    check("bounce_y_back", {2'b0, ypos}, 12'd508);
    check("bounce_x_back", {2'b0, xpos}, 12'd776);

    // Opposing buttons hold position
    mode = 2'd1; left = 1'b1; right = 1'b1; up = 1'b1; down = 1'b1;
    ticks(4);
    check("hold_x", {2'b0, xpos}, 12'd776);
    check("hold_y", {2'b0, ypos}, 12'd508);
    check("bg_prio", background, 12'hFF0);
    right = 1'b0; up = 1'b0; down = 1'b0;
    @(negedge clk);
    check("bg_left", background, 12'h0FF);
    right = 1'b1; left = 1'b0;
    repeat (1000) @(negedge clk);
    check("no_tick_x", {2'b0, xpos}, 12'd776);
    check("no_tick_y", {2'b0, ypos}, 12'd508);

    // Pixel path around a freshly reset sprite
    right = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    h_count = 10'd445; v_count = 10'd250;
    @(negedge clk);
    check("pix_445", rgb, EdgeCol);
    check("in_445", {11'b0, in_sprite}, 12'd1);
    h_count = 10'd444;
    @(negedge clk);
    check("pix_444", rgb, 12'hFFF);
    check("in_444", {11'b0, in_sprite}, 12'd0);
    h_count = 10'd446;
    @(negedge clk);
    check("pix_446", rgb, 12'hF00);
    h_count = 10'd455;
    @(negedge clk);
    check("pix_455", rgb, EdgeCol);
    h_count = 10'd456;
    @(negedge clk);
    check("pix_456", rgb, 12'hFFF);
    h_count = 10'd450; v_count = 10'd244;
    @(negedge clk);
    check("pix_v244", rgb, 12'hFFF);
    v_count = 10'd245;
    @(negedge clk);
    check("pix_v245", rgb, EdgeCol);

    // Asynchronous reset in the middle of a tick while moving
    v_count = 10'd250; mode = 2'd0; right = 1'b1;
    ticks(2);
    check("pre_rst_x", {2'b0, xpos}, 12'd454);
    check("pre_rst_rgb", rgb, 12'hF00);
    @(negedge clk) frame_tick = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("async_x", {2'b0, xpos}, 12'd450);
    check("async_y", {2'b0, ypos}, 12'd250);
    check("async_rgb", rgb, 12'hFFF);
    @(negedge clk) begin
      rst = 1'b0;
      frame_tick = 1'b0;
    end
    tick();
    check("post_rst_x", {2'b0, xpos}, 12'd452);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
